// File: rtl/r2sdf_frame_ctrl.sv
// r2sdf_frame_ctrl: frame sequencer for a radix-2 SDF FFT pipeline (input framing, in-flight tracking, output framing, error flags)
module r2sdf_frame_ctrl #(
    parameter int N            = 3,
    parameter int MAX_INFLIGHT = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         clr_err,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         bf_start_ip,
    output logic         bf_sample_en,
    output logic         bf_zero,
    output logic [N-1:0] in_idx,
    input  logic         bf_start_op,
    output logic         out_valid,
    output logic [N-1:0] out_idx,
    output logic         out_last,
    output logic         frame_done,
    output logic [2:0]   inflight,
    output logic         busy,
    output logic         err_underrun,
    output logic         err_timeout,
    output logic         err_spurious
);
    localparam int AW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, RUN} in_state_t;
    typedef enum logic {O_IDLE, O_DRAIN} out_state_t;

    in_state_t   in_st_q, in_st_d;
    out_state_t  out_st_q, out_st_d;
    logic [N-1:0] in_idx_q, in_idx_d, out_idx_q, out_idx_d;
    logic [2:0]   inflight_q, inflight_d, cnt_q, cnt_d, cnt_mid;
    logic [AW-1:0] age_q [MAX_INFLIGHT];
    logic [AW-1:0] age_d [MAX_INFLIGHT];
    logic [AW-1:0] age_inc [MAX_INFLIGHT];
    logic room, start, last, accept, spur, tmo, pop;
    logic err_u_q, err_t_q, err_s_q;

    // Back-to-back frames fall out of returning to IDLE after F-1: IDLE starts combinationally, so no gap.
    assign room         = inflight_q < 3'(MAX_INFLIGHT);
    assign in_ready     = (in_st_q == RUN) | (enable & room);
    assign start        = (in_st_q == IDLE) & in_valid & in_ready;
    assign bf_start_ip  = start;
    assign bf_sample_en = (in_st_q == RUN) | start;
    assign bf_zero      = (in_st_q == RUN) & ~in_valid;
    assign in_idx       = in_idx_q;

    always_comb begin
        in_st_d  = in_st_q;
        in_idx_d = in_idx_q;
        if (in_st_q == IDLE) begin
            if (start) begin
                in_st_d  = RUN;
                in_idx_d = N'(1);
            end
        end else begin
            in_idx_d = in_idx_q + 1'b1;
            if (&in_idx_q) in_st_d = IDLE;
        end
    end

    assign last   = (out_st_q == O_DRAIN) & (&out_idx_q);
    assign accept = bf_start_op & (cnt_q != '0) & ((out_st_q == O_IDLE) | last);
    assign spur   = bf_start_op & ~accept;
    assign tmo    = (cnt_q != '0) & (age_q[0] >= AW'(TIMEOUT)) & ~accept;
    assign pop    = accept | tmo;

    assign out_st_d  = accept ? O_DRAIN : (last ? O_IDLE : out_st_q);
    assign out_idx_d = accept ? '0 : ((out_st_q == O_DRAIN) ? out_idx_q + 1'b1 : out_idx_q);

    // Age queue: head at index 0; every entry ages (saturating) so each frame's age counts from its own start.
    always_comb begin
        cnt_mid = cnt_q - {2'b0, pop};
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            age_inc[i] = (&age_q[i]) ? age_q[i] : age_q[i] + 1'b1;
            age_d[i]   = age_inc[i];
        end
        if (pop) begin
            for (int i = 0; i < MAX_INFLIGHT - 1; i++) age_d[i] = age_inc[i + 1];
            age_d[MAX_INFLIGHT-1] = '0;
        end
        for (int i = 0; i < MAX_INFLIGHT; i++)
            if (start && cnt_mid == 3'(i)) age_d[i] = AW'(1);
        cnt_d = cnt_mid + {2'b0, start};
    end

    assign inflight_d = inflight_q + {2'b0, start} - {2'b0, last} - {2'b0, tmo};

    always_ff @(posedge clk) begin
        if (reset) begin
            in_st_q    <= IDLE;
            out_st_q   <= O_IDLE;
            in_idx_q   <= '0;
            out_idx_q  <= '0;
            inflight_q <= '0;
            cnt_q      <= '0;
            age_q      <= '{default: '0};
            err_u_q    <= 1'b0;
            err_t_q    <= 1'b0;
            err_s_q    <= 1'b0;
        end else begin
            in_st_q    <= in_st_d;
            out_st_q   <= out_st_d;
            in_idx_q   <= in_idx_d;
            out_idx_q  <= out_idx_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            age_q      <= age_d;
            err_u_q    <= (err_u_q & ~clr_err) | bf_zero;
            err_t_q    <= (err_t_q & ~clr_err) | tmo;
            err_s_q    <= (err_s_q & ~clr_err) | spur;
        end
    end

    assign out_valid    = out_st_q == O_DRAIN;
    assign out_idx      = out_idx_q;
    assign out_last     = last;
    assign frame_done   = last;
    assign inflight     = inflight_q;
    assign busy         = (in_st_q == RUN) | (inflight_q != '0);
    assign err_underrun = err_u_q;
    assign err_timeout  = err_t_q;
    assign err_spurious = err_s_q;
endmodule
